// File: rtl/pci_pkg.sv
// pci_pkg: bus command codes and the target FSM encoding shared by the PCI device blocks.
package pci_pkg;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  typedef enum logic [2:0] {IDLE, B_BUSY, WAIT, DATA, TURN} tgt_state_e;
  function automatic logic cmd_supported(input logic [3:0] cmd);
    return cmd == CMD_MEM_RD || cmd == CMD_MEM_WR;
  endfunction
endpackage

// File: rtl/pci_be_merge.sv
// pci_be_merge: replaces the bytes of a stored word whose active-low byte enable is asserted.
module pci_be_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] ad_i,
  input  logic [3:0]  be_n_i,
  output logic [31:0] new_o
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign new_o[8*b +: 8] = be_n_i[b] ? old_i[8*b +: 8] : ad_i[8*b +: 8];
  end
endmodule

// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI memory target, DEPTH x 32-bit window at BASE_ADDR, linear bursts, disconnect at window end.
// Define PCI_TGT_PARITY_EN to drive PAR one cycle after each read data phase.
module pci_target_mem
  import pci_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [31:0] AD,
  input  logic [3:0]  C_BE,
  input  logic        frame,
  input  logic        irdy,
  inout  wire         trdy,
  inout  wire         devsel,
  inout  wire         stop,
  inout  wire         par,
  output logic        mem_hit
);
  localparam int AW = $clog2(DEPTH);
  tgt_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          disc_q, disc_d;
  logic          frame_q;
  logic          mem_hit_q;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_word, wr_word;
  logic          addr_phase, hit, xfer, last_idx;
  logic          ctl_oe, trdy_v, devsel_v, stop_v, ad_oe;
  logic          ad_unused;
  assign ad_unused  = ^AD[1:0];
  // Only a genuine FRAME# falling edge seen in IDLE starts a transaction.
  assign addr_phase = state_q == IDLE && frame_q && !frame;
  assign hit        = AD[31:AW+2] == BASE_ADDR[31:AW+2] && cmd_supported(C_BE);
  assign xfer       = state_q == DATA && !disc_q && !irdy;
  assign last_idx   = idx_q == AW'(DEPTH - 1);
  assign rd_word    = mem_q[idx_q];
  pci_be_merge u_merge (
    .old_i  (rd_word),
    .ad_i   (AD),
    .be_n_i (C_BE),
    .new_o  (wr_word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      disc_q    <= 1'b0;
      frame_q   <= 1'b1;
      mem_hit_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      disc_q    <= disc_d;
      frame_q   <= frame;
      mem_hit_q <= xfer;
      if (xfer && !rd_q) mem_q[idx_q] <= wr_word;
    end
  end
  // Reads spend one extra WAIT cycle as the AD turnaround; writes with no wait states go straight to DATA.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    disc_d  = disc_q;
    case (state_q)
      IDLE: if (addr_phase) begin
        rd_d    = C_BE == CMD_MEM_RD;
        idx_d   = AD[AW+1:2];
        cnt_d   = C_BE == CMD_MEM_RD ? 3'(WAIT_STATES) : 3'(WAIT_STATES - 1);
        state_d = !hit ? B_BUSY : (C_BE == CMD_MEM_WR && WAIT_STATES == 0) ? DATA : WAIT;
      end
      B_BUSY: state_d = frame && irdy ? IDLE : B_BUSY;
      WAIT: begin
        cnt_d   = cnt_q == 3'd0 ? 3'd0 : cnt_q - 3'd1;
        state_d = cnt_q == 3'd0 ? DATA : WAIT;
      end
      DATA: if (disc_q) begin
        state_d = frame ? TURN : DATA;
        disc_d  = !frame;
      end else if (xfer) begin
        idx_d   = last_idx ? idx_q : idx_q + 1'b1;
        state_d = frame ? TURN : DATA;
        disc_d  = !frame && last_idx;
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ctl_oe   = state_q inside {WAIT, DATA, TURN};
    devsel_v = state_q == TURN;
    trdy_v   = !(state_q == DATA && !disc_q);
    stop_v   = !(state_q == DATA && (disc_q || (last_idx && !frame)));
    ad_oe    = rd_q && state_q inside {WAIT, DATA};
  end
  assign trdy    = ctl_oe ? trdy_v : 1'bz;
  assign devsel  = ctl_oe ? devsel_v : 1'bz;
  assign stop    = ctl_oe ? stop_v : 1'bz;
  assign AD      = ad_oe ? rd_word : 32'bz;
  assign mem_hit = mem_hit_q;
`ifdef PCI_TGT_PARITY_EN
  logic par_q, par_oe_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q    <= 1'b0;
      par_oe_q <= 1'b0;
    end else begin
      par_q    <= ^{rd_word, C_BE};
      par_oe_q <= ad_oe;
    end
  end
  assign par = par_oe_q ? par_q : 1'bz;
`else
  assign par = 1'bz;
`endif
endmodule
